// File: rtl/sel_multi_rr_if.sv
// Request/grant bundle between a select leaf and its neighbours in the issue select tree.
interface sel_multi_rr_if #(
    parameter int NREQ = 8,
    parameter int NGNT = 2
) ();
    localparam int IDXW = $clog2(NREQ);

    logic [NREQ-1:0]      req_i;
    logic                 grant_i;
    logic [NREQ-1:0]      grant_o;
    logic [NGNT-1:0]      gnt_vld_o;
    logic [NGNT*IDXW-1:0] gnt_idx_o;
    logic                 req_o;
    logic [IDXW-1:0]      ptr_o;

    modport master (
        output req_i, grant_i,
        input  grant_o, gnt_vld_o, gnt_idx_o, req_o, ptr_o
    );

    modport slave (
        input  req_i, grant_i,
        output grant_o, gnt_vld_o, gnt_idx_o, req_o, ptr_o
    );
endinterface

// File: rtl/sel_multi_rr.sv
// Multi-grant select leaf: up to NGNT of NREQ requesters per cycle, either round-robin
// from a registered pointer or fixed priority with a starvation override.
module sel_multi_rr #(
    parameter int NREQ     = 8,
    parameter int NGNT     = 2,
    parameter int MODE     = 1,
    parameter int STARVE_W = 2
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    sel_multi_rr_if.slave  bus
);
    localparam int IDXW = $clog2(NREQ);
    localparam int CW   = IDXW + 1;
    localparam logic [STARVE_W-1:0] THRESH = '1;

    logic [IDXW-1:0]      r_ptr;
    logic [STARVE_W-1:0]  r_age [NREQ];

    logic                 w_en;
    logic [NREQ-1:0]      w_starve;
    logic [NREQ-1:0]      w_sel;
    logic [NGNT-1:0]      w_vld;
    logic [NGNT*IDXW-1:0] w_idx;
    logic [IDXW-1:0]      w_last;

    assign w_en = rst_n_i & bus.grant_i;

    always_comb begin
        w_starve = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_starve[k] = (MODE == 0) && bus.req_i[k] && (r_age[k] == THRESH);
        end
    end

    // Slot s is filled by the request whose running count of earlier takers equals s.
    always_comb begin
        logic [CW-1:0]   w_cnt;
        logic [CW-1:0]   w_pos;
        logic [IDXW-1:0] w_k;
        logic [IDXW-1:0] w_first;
        logic            w_found;
        logic            w_take;

        w_sel   = '0;
        w_vld   = '0;
        w_idx   = '0;
        w_last  = '0;
        w_cnt   = '0;
        w_pos   = '0;
        w_k     = '0;
        w_first = '0;
        w_found = 1'b0;
        w_take  = 1'b0;

        if (MODE == 1) begin
            for (int off = 0; off < NREQ; off++) begin
                w_pos = {1'b0, r_ptr} + CW'(off);
                if (w_pos >= CW'(NREQ)) begin
                    w_pos = w_pos - CW'(NREQ);
                end
                w_k    = w_pos[IDXW-1:0];
                w_take = bus.req_i[w_k];
                for (int s = 0; s < NGNT; s++) begin
                    if (w_take && (w_cnt == CW'(s))) begin
                        w_sel[w_k]              = 1'b1;
                        w_vld[s]                = 1'b1;
                        w_idx[s*IDXW +: IDXW]   = w_k;
                        w_last                  = w_k;
                    end
                end
                w_cnt = w_cnt + CW'(w_take);
            end
        end else begin
            for (int j = NREQ - 1; j >= 0; j--) begin
                if (w_starve[j]) begin
                    w_found = 1'b1;
                    w_first = IDXW'(j);
                end
            end
            if (w_found) begin
                w_sel[w_first]  = 1'b1;
                w_vld[0]        = 1'b1;
                w_idx[0 +: IDXW] = w_first;
                w_last          = w_first;
                w_cnt           = CW'(1);
            end
            for (int j = 0; j < NREQ; j++) begin
                w_take = bus.req_i[j] && !(w_found && (w_first == IDXW'(j)));
                for (int s = 0; s < NGNT; s++) begin
                    if (w_take && (w_cnt == CW'(s))) begin
                        w_sel[j]              = 1'b1;
                        w_vld[s]              = 1'b1;
                        w_idx[s*IDXW +: IDXW] = IDXW'(j);
                        w_last                = IDXW'(j);
                    end
                end
                w_cnt = w_cnt + CW'(w_take);
            end
        end
    end

    // Pointer restarts just past the last requester served this cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_ptr <= '0;
        end else if ((MODE == 1) && bus.grant_i && w_vld[0]) begin
            r_ptr <= (w_last == IDXW'(NREQ - 1)) ? '0 : w_last + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NREQ; k++) begin
            if (!rst_n_i || (MODE != 0)) begin
                r_age[k] <= '0;
            end else if (bus.grant_i) begin
                if (!bus.req_i[k] || w_sel[k]) begin
                    r_age[k] <= '0;
                end else if (r_age[k] != THRESH) begin
                    r_age[k] <= r_age[k] + 1'b1;
                end
            end
        end
    end

    assign bus.grant_o   = w_en ? w_sel : '0;
    assign bus.gnt_vld_o = w_en ? w_vld : '0;
    assign bus.gnt_idx_o = w_en ? w_idx : '0;
    assign bus.req_o     = |bus.req_i;
    assign bus.ptr_o     = r_ptr;

endmodule
